// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ALU operand stage: operand selects, register-index width, CONST4.
package alu_operand_stage_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned CONST4_VAL = 4;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2,
    A_RSV  = 2'd3
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2    = 2'd0,
    B_IMM    = 2'd1,
    B_CONST4 = 2'd2,
    B_RSV    = 2'd3
  } b_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Per-operand forwarding select: lowest-index matching source wins, x0 reads zero.
module alu_fwd_select
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2
) (
  input  logic [REG_AW-1:0]      rs_addr,
  input  logic [XLEN-1:0]        rs_data,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_busy,
  input  logic [REG_AW*NFWD-1:0] fwd_rd,
  input  logic [XLEN*NFWD-1:0]   fwd_data,
  output logic [XLEN-1:0]        op_data,
  output logic                   op_busy
);

  logic hit;

  always_comb begin
    op_data = rs_data;
    op_busy = 1'b0;
    hit     = 1'b0;
    // The first hit latches, so a younger busy source masks older ready data.
    for (int unsigned n = 0; n < NFWD; n++) begin
      if (!hit && fwd_valid[n] && (fwd_rd[n*REG_AW +: REG_AW] == rs_addr)) begin
        hit     = 1'b1;
        op_data = fwd_data[n*XLEN +: XLEN];
        op_busy = fwd_busy[n];
      end
    end
    if (rs_addr == '0) begin
      op_data = '0;
      op_busy = 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarded operand muxing, hazard stall, one-entry output register.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        pc,
  input  logic [1:0]             a_sel,
  input  logic [1:0]             b_sel,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_busy,
  input  logic [5*NFWD-1:0]      fwd_rd,
  input  logic [XLEN*NFWD-1:0]   fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        op_a,
  output logic [XLEN-1:0]        op_b,
  output logic [XLEN-1:0]        store_data,
  output logic [CNTW-1:0]        stall_cnt
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            rs1_busy, rs2_busy;
  logic            hazard, accept;
  a_sel_e          a_sel_e_w;
  b_sel_e          b_sel_e_w;

  logic [XLEN-1:0] op_a_d, op_a_q;
  logic [XLEN-1:0] op_b_d, op_b_q;
  logic [XLEN-1:0] store_data_d, store_data_q;
  logic            out_valid_d, out_valid_q;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;

  alu_fwd_select #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
    .rs_addr   (rs1_addr),
    .rs_data   (rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .op_data   (rs1_fwd),
    .op_busy   (rs1_busy)
  );

  alu_fwd_select #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
    .rs_addr   (rs2_addr),
    .rs_data   (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .op_data   (rs2_fwd),
    .op_busy   (rs2_busy)
  );

  assign a_sel_e_w = a_sel_e'(a_sel);
  assign b_sel_e_w = b_sel_e'(b_sel);

  // rs2 always counts because store_data carries it regardless of b_sel.
  assign hazard   = in_valid && (((a_sel_e_w == A_RS1) && rs1_busy) || rs2_busy);
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    out_valid_d  = out_valid_q;
    stall_cnt_d  = stall_cnt_q;

    if (accept) begin
      unique case (a_sel_e_w)
        A_RS1:   op_a_d = rs1_fwd;
        A_PC:    op_a_d = pc;
        A_ZERO:  op_a_d = '0;
        A_RSV:   op_a_d = '0;
        default: op_a_d = '0;
      endcase
      unique case (b_sel_e_w)
        B_RS2:    op_b_d = rs2_fwd;
        B_IMM:    op_b_d = imm;
        B_CONST4: op_b_d = XLEN'(CONST4_VAL);
        B_RSV:    op_b_d = imm;
        default:  op_b_d = imm;
      endcase
      store_data_d = rs2_fwd;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
      out_valid_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
      out_valid_q  <= out_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign store_data = store_data_q;
  assign out_valid  = out_valid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: default instance plus a CNTW=2 instance sharing inputs.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [1:0]  a_sel, b_sel;
  logic [1:0]  fwd_valid, fwd_busy;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;

  logic        in_ready, out_valid;
  logic [31:0] op_a, op_b, store_data;
  logic [15:0] stall_cnt;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_op_a, d2_op_b, d2_store_data;
  logic [1:0]  d2_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .NFWD(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .a_sel(a_sel), .b_sel(b_sel),
    .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .store_data(store_data), .stall_cnt(stall_cnt)
  );

  alu_operand_stage #(.XLEN(32), .NFWD(2), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .a_sel(a_sel), .b_sel(b_sel),
    .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .op_a(d2_op_a), .op_b(d2_op_b),
    .store_data(d2_store_data), .stall_cnt(d2_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
    imm = '0; pc = '0; a_sel = '0; b_sel = '0;
    fwd_valid = '0; fwd_busy = '0; fwd_rd = '0; fwd_data = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op_a", 64'(op_a), 64'd0);
    chk("rst_op_b", 64'(op_b), 64'd0);
    chk("rst_store", 64'(store_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // plain issue, no forwarding
    in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd1;
    rs1_addr = 5'd1; rs1_data = 32'd5; imm = 32'd7;
    rs2_addr = 5'd2; rs2_data = 32'd9;
    #1 chk("basic_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_op_a", 64'(op_a), 64'd5);
    chk("basic_op_b", 64'(op_b), 64'd7);
    chk("basic_store", 64'(store_data), 64'd9);

    // both sources match rs1: youngest wins; drain+accept same cycle
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA};
    rs1_addr = 5'd3; b_sel = 2'd2;
    #1 chk("fwd_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fwd_op_a", 64'(op_a), 64'hAA);
    chk("fwd_op_b_const4", 64'(op_b), 64'd4);
    chk("fwd_store", 64'(store_data), 64'd9);
    chk("fwd_out_valid", 64'(out_valid), 64'd1);

    // x0 never forwarded
    rs1_addr = 5'd0; rs1_data = 32'h55; fwd_rd = {5'd0, 5'd0};
    a_sel = 2'd0; b_sel = 2'd0; rs2_addr = 5'd0; rs2_data = 32'h66;
    tick();
    chk("x0_op_a", 64'(op_a), 64'd0);
    chk("x0_op_b", 64'(op_b), 64'd0);
    chk("x0_store", 64'(store_data), 64'd0);

    // PC / reserved B selects
    fwd_valid = 2'b00; a_sel = 2'd1; pc = 32'h1000; b_sel = 2'd3; imm = 32'h20;
    tick();
    chk("pc_op_a", 64'(op_a), 64'h1000);
    chk("rsvb_op_b", 64'(op_b), 64'h20);

    a_sel = 2'd3; b_sel = 2'd2;
    tick();
    chk("rsva_op_a", 64'(op_a), 64'd0);
    chk("rsva_op_b", 64'(op_b), 64'd4);

    // only the older source matches
    fwd_valid = 2'b10; fwd_rd = {5'd3, 5'd0}; a_sel = 2'd0; rs1_addr = 5'd3;
    tick();
    chk("old_fwd_op_a", 64'(op_a), 64'hBB);

    // busy youngest match on rs2 for three cycles
    in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd1;
    rs1_addr = 5'd1; rs1_data = 32'd5; imm = 32'd7;
    rs2_addr = 5'd4; rs2_data = 32'd1;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd4}; fwd_data = {32'h99, 32'h44}; fwd_busy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 chk("haz_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    chk("haz_stall3", 64'(stall_cnt), 64'd3);
    chk("haz_d2_stall3", 64'(d2_stall_cnt), 64'd3);
    chk("haz_drained", 64'(out_valid), 64'd0);
    fwd_busy = 2'b00;
    #1 chk("haz_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("haz_accept_valid", 64'(out_valid), 64'd1);
    chk("haz_accept_store", 64'(store_data), 64'h44);
    chk("haz_accept_op_a", 64'(op_a), 64'd5);

    // younger busy beats older ready data for the same register
    fwd_valid = 2'b11; fwd_rd = {5'd4, 5'd4}; fwd_busy = 2'b01;
    #1 chk("prio_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("prio_stall", 64'(stall_cnt), 64'd4);
    chk("prio_d2_sat", 64'(d2_stall_cnt), 64'd3);

    // busy match on rs1 ignored when operand A is PC
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_busy = 2'b01;
    rs1_addr = 5'd1; a_sel = 2'd1; rs2_addr = 5'd2; rs2_data = 32'h12;
    #1 chk("unused_rs1_ready", 64'(in_ready), 64'd1);
    tick();
    chk("unused_rs1_op_a", 64'(op_a), 64'h1000);
    chk("unused_rs1_stall", 64'(stall_cnt), 64'd4);

    // backpressure holds outputs, then back-to-back without a bubble
    fwd_valid = '0; fwd_busy = '0;
    a_sel = 2'd0; b_sel = 2'd1; rs1_addr = 5'd1; rs1_data = 32'h11;
    imm = 32'h22; rs2_addr = 5'd2; rs2_data = 32'h33;
    tick();
    chk("bp_load_op_a", 64'(op_a), 64'h11);
    out_ready = 1'b0; rs1_data = 32'h77; imm = 32'h88;
    #1 chk("bp_in_ready0", 64'(in_ready), 64'd0);
    tick();
    chk("bp_hold1_op_a", 64'(op_a), 64'h11);
    chk("bp_hold1_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_hold2_op_b", 64'(op_b), 64'h22);
    chk("bp_hold2_store", 64'(store_data), 64'h33);
    chk("bp_hold2_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_op_a", 64'(op_a), 64'h77);
    chk("b2b_op_b", 64'(op_b), 64'h88);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // reset mid-transfer overrides a concurrent accept
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_op_a", 64'(op_a), 64'd0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mid_rst_d2_stall", 64'(d2_stall_cnt), 64'd0);
    #1 chk("post_rst_ready", 64'(in_ready), 64'd1);

    // six hazard cycles: narrow counter saturates at 3
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd2}; fwd_busy = 2'b01; rs2_addr = 5'd2;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_d2_stall", 64'(d2_stall_cnt), 64'd3);
    chk("sat_stall", 64'(stall_cnt), 64'd6);
    in_valid = 1'b0;
    tick();
    chk("sat_d2_hold", 64'(d2_stall_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
